// File: rtl/spi_fifo.sv
// Single-clock frame FIFO shared by the SPI transmit and receive channels.
// Registered read data, occupancy flags and overflow/underflow event pulses.
module spi_fifo #(
  parameter int unsigned CFG_FRAME_SIZE = 8,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                              pclk,
  input  logic                              aresetn,
  input  logic                              clr_fifo,
  input  logic                              fifo_write,
  input  logic [CFG_FRAME_SIZE-1:0]         data_in,
  input  logic                              fifo_read,
  output logic [CFG_FRAME_SIZE-1:0]         data_out,
  output logic                              fifo_full,
  output logic                              fifo_full_next,
  output logic                              fifo_empty,
  output logic                              fifo_empty_next,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overflow,
  output logic                              underflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [CFG_FRAME_SIZE-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic [CW-1:0]             count_nxt;
  logic                      rd_ok;
  logic                      wr_ok;

  // Acceptance: a read frees a slot, so a write into a full FIFO is allowed alongside it.
  always_comb begin
    rd_ok     = 1'b0;
    wr_ok     = 1'b0;
    count_nxt = fifo_count;
    if (clr_fifo) begin
      count_nxt = '0;
    end else begin
      rd_ok = fifo_read && (fifo_count != '0);
      wr_ok = fifo_write && ((fifo_count != CW'(FIFO_DEPTH)) || rd_ok);
      if (wr_ok && !rd_ok) begin
        count_nxt = fifo_count + CW'(1);
      end else if (rd_ok && !wr_ok) begin
        count_nxt = fifo_count - CW'(1);
      end
    end
  end

  // Storage array; contents survive reset and clear.
  always_ff @(posedge pclk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy, read data, flags and event pulses.
  always_ff @(posedge pclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_count      <= '0;
      data_out        <= '0;
      overflow        <= 1'b0;
      underflow       <= 1'b0;
      fifo_full       <= 1'b0;
      fifo_full_next  <= 1'b0;
      fifo_empty      <= 1'b1;
      fifo_empty_next <= 1'b0;
    end else begin
      fifo_count      <= count_nxt;
      fifo_full       <= (count_nxt == CW'(FIFO_DEPTH));
      fifo_full_next  <= (count_nxt == CW'(FIFO_DEPTH - 1));
      fifo_empty      <= (count_nxt == '0);
      fifo_empty_next <= (count_nxt == CW'(1));
      if (clr_fifo) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        data_out  <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        overflow  <= fifo_write && !wr_ok;
        underflow <= fifo_read && !rd_ok;
        if (wr_ok) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (rd_ok) begin
          rd_ptr   <= rd_ptr + AW'(1);
          data_out <= mem[rd_ptr];
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_fifo.sv
// Directed bench for spi_fifo (DEPTH 4, 8-bit frames) with a queue scoreboard.
module tb_spi_fifo;

  logic       pclk = 1'b0;
  logic       aresetn;
  logic       clr_fifo;
  logic       fifo_write;
  logic [7:0] data_in;
  logic       fifo_read;
  logic [7:0] data_out;
  logic       fifo_full;
  logic       fifo_full_next;
  logic       fifo_empty;
  logic       fifo_empty_next;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb_q[$];
  logic [7:0] exp_dout = 8'h00;
  int         max_cnt;

  spi_fifo #(.CFG_FRAME_SIZE(8), .FIFO_DEPTH(4)) dut (
    .pclk            (pclk),
    .aresetn         (aresetn),
    .clr_fifo        (clr_fifo),
    .fifo_write      (fifo_write),
    .data_in         (data_in),
    .fifo_read       (fifo_read),
    .data_out        (data_out),
    .fifo_full       (fifo_full),
    .fifo_full_next  (fifo_full_next),
    .fifo_empty      (fifo_empty),
    .fifo_empty_next (fifo_empty_next),
    .fifo_count      (fifo_count),
    .overflow        (overflow),
    .underflow       (underflow)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic exp_ovf, input logic exp_unf);
    int c;
    c = sb_q.size();
    chk({tag, ":count"},      32'(fifo_count),      32'(c));
    chk({tag, ":empty"},      32'(fifo_empty),      32'(c == 0));
    chk({tag, ":full"},       32'(fifo_full),       32'(c == 4));
    chk({tag, ":full_next"},  32'(fifo_full_next),  32'(c == 3));
    chk({tag, ":empty_next"}, 32'(fifo_empty_next), 32'(c == 1));
    chk({tag, ":data_out"},   32'(data_out),        32'(exp_dout));
    chk({tag, ":overflow"},   32'(overflow),        32'(exp_ovf));
    chk({tag, ":underflow"},  32'(underflow),       32'(exp_unf));
  endtask

  // One clock: drive at negedge, scoreboard update, check 1 time unit after the edge.
  task automatic cyc(input string tag, input logic wr, input logic rd,
                     input logic [7:0] din, input logic clr);
    logic rd_ok, wr_ok, e_ovf, e_unf;
    @(negedge pclk);
    fifo_write = wr;
    fifo_read  = rd;
    data_in    = din;
    clr_fifo   = clr;
    @(posedge pclk);
    #1;
    e_ovf = 1'b0;
    e_unf = 1'b0;
    if (clr) begin
      sb_q.delete();
      exp_dout = 8'h00;
    end else begin
      rd_ok = rd && (sb_q.size() != 0);
      wr_ok = wr && ((sb_q.size() != 4) || rd_ok);
      if (rd_ok) exp_dout = sb_q.pop_front();
      if (wr_ok) sb_q.push_back(din);
      e_ovf = wr && !wr_ok;
      e_unf = rd && !rd_ok;
    end
    if (sb_q.size() > max_cnt) max_cnt = sb_q.size();
    chk_state(tag, e_ovf, e_unf);
    fifo_write = 1'b0;
    fifo_read  = 1'b0;
    clr_fifo   = 1'b0;
  endtask

  initial begin
    aresetn    = 1'b0;
    clr_fifo   = 1'b0;
    fifo_write = 1'b0;
    fifo_read  = 1'b0;
    data_in    = 8'h00;
    repeat (2) @(posedge pclk);
    #1;
    chk_state("reset", 1'b0, 1'b0);
    @(negedge pclk);
    aresetn = 1'b1;
    cyc("idle", 0, 0, 8'h00, 0);

    // Fill and drain
    cyc("wr11", 1, 0, 8'h11, 0);
    cyc("wr22", 1, 0, 8'h22, 0);
    cyc("wr33", 1, 0, 8'h33, 0);
    chk("fill:full_next_after3", 32'(fifo_full_next), 32'd1);
    cyc("wr44", 1, 0, 8'h44, 0);
    chk("fill:full_after4", 32'(fifo_full), 32'd1);
    cyc("ovf_wr", 1, 0, 8'h99, 0);
    chk("ovf:pulse", 32'(overflow), 32'd1);
    cyc("ovf_idle", 0, 0, 8'h00, 0);
    chk("ovf:one_cycle", 32'(overflow), 32'd0);
    cyc("rd1", 0, 1, 8'h00, 0);
    chk("drain:d11", 32'(data_out), 32'h11);
    cyc("rd2", 0, 1, 8'h00, 0);
    chk("drain:d22", 32'(data_out), 32'h22);
    cyc("rd3", 0, 1, 8'h00, 0);
    chk("drain:d33", 32'(data_out), 32'h33);
    chk("drain:empty_next", 32'(fifo_empty_next), 32'd1);
    cyc("rd4", 0, 1, 8'h00, 0);
    chk("drain:d44", 32'(data_out), 32'h44);
    chk("drain:empty", 32'(fifo_empty), 32'd1);
    cyc("unf_rd", 0, 1, 8'h00, 0);
    chk("unf:pulse", 32'(underflow), 32'd1);
    chk("unf:hold44", 32'(data_out), 32'h44);
    cyc("unf_idle", 0, 0, 8'h00, 0);
    chk("unf:one_cycle", 32'(underflow), 32'd0);

    // Simultaneous read+write when full, then drain
    cyc("f_wr11", 1, 0, 8'h11, 0);
    cyc("f_wr22", 1, 0, 8'h22, 0);
    cyc("f_wr33", 1, 0, 8'h33, 0);
    cyc("f_wr44", 1, 0, 8'h44, 0);
    cyc("full_rw55", 1, 1, 8'h55, 0);
    chk("full_rw:count4", 32'(fifo_count), 32'd4);
    chk("full_rw:no_ovf", 32'(overflow), 32'd0);
    cyc("d_rd1", 0, 1, 8'h00, 0);
    chk("full_rw:d22", 32'(data_out), 32'h22);
    cyc("d_rd2", 0, 1, 8'h00, 0);
    cyc("d_rd3", 0, 1, 8'h00, 0);
    cyc("d_rd4", 0, 1, 8'h00, 0);
    chk("full_rw:d55", 32'(data_out), 32'h55);

    // Simultaneous read+write when empty
    cyc("empty_rw66", 1, 1, 8'h66, 0);
    chk("empty_rw:count1", 32'(fifo_count), 32'd1);
    chk("empty_rw:unf", 32'(underflow), 32'd1);
    chk("empty_rw:hold55", 32'(data_out), 32'h55);
    cyc("rd66", 0, 1, 8'h00, 0);
    chk("empty_rw:d66", 32'(data_out), 32'h66);

    // Wrap-around with alternating write/read
    max_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc($sformatf("wrap_wr%0d", i), 1, 0, 8'(i), 0);
      cyc($sformatf("wrap_rd%0d", i), 0, 1, 8'h00, 0);
      chk($sformatf("wrap:d%0d", i), 32'(data_out), 32'(i));
    end
    chk("wrap:max_count", 32'(max_cnt), 32'd1);

    // Clear with a concurrent write
    cyc("c_wrA1", 1, 0, 8'hA1, 0);
    cyc("c_wrA2", 1, 0, 8'hA2, 0);
    cyc("c_wrA3", 1, 0, 8'hA3, 0);
    cyc("clr_wr77", 1, 0, 8'h77, 1);
    chk("clr:count0", 32'(fifo_count), 32'd0);
    chk("clr:empty", 32'(fifo_empty), 32'd1);
    chk("clr:no_ovf", 32'(overflow), 32'd0);
    cyc("clr_rd", 0, 1, 8'h00, 0);
    chk("clr:discarded", 32'(underflow), 32'd1);
    cyc("clr_wrB1", 1, 0, 8'hB1, 0);
    cyc("clr_rdB1", 0, 1, 8'h00, 0);
    chk("clr:ptr_reset", 32'(data_out), 32'hB1);

    // Asynchronous reset between edges
    cyc("a_wrC1", 1, 0, 8'hC1, 0);
    cyc("a_wrC2", 1, 0, 8'hC2, 0);
    cyc("a_rdC1", 0, 1, 8'h00, 0);
    #2;
    aresetn = 1'b0;
    #1;
    sb_q.delete();
    exp_dout = 8'h00;
    chk("async:count0", 32'(fifo_count), 32'd0);
    chk("async:dout0", 32'(data_out), 32'd0);
    chk_state("async", 1'b0, 1'b0);
    @(negedge pclk);
    aresetn = 1'b1;
    cyc("post_rst_wr", 1, 0, 8'hD1, 0);
    cyc("post_rst_rd", 0, 1, 8'h00, 0);
    chk("async:post_data", 32'(data_out), 32'hD1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_fifo.md
# spi_fifo

Synchronous single-clock FIFO instantiated twice in the SPI core, once as the transmit FIFO and once as the receive FIFO, between the APB register file and the SPI shift engine. It buffers frames of `CFG_FRAME_SIZE` bits, honours the register file's one-cycle clear strobe, and produces the full, empty, full-next and empty-next flags that feed the status and interrupt logic. It also flags write-when-full and read-when-empty attempts. Those flags are the source of the channel overflow and underflow events.

## Interface
- `CFG_FRAME_SIZE`, default 8: data width in bits, 4..32.
- `FIFO_DEPTH`, default 4: number of entries. Must be a power of two, ≥2.
- `pclk` in 1: clock; every flop is rising-edge.
- `aresetn` in 1: reset, asynchronous, active-low.
- `clr_fifo` in 1: synchronous flush strobe (driven by `clr_txfifo`/`clr_rxfifo`).
- `fifo_write` in 1: write request.
- `data_in` in `CFG_FRAME_SIZE`: write data.
- `fifo_read` in 1: read request.
- `data_out` out `CFG_FRAME_SIZE`: read data, registered.
- `fifo_full` out 1: count == `FIFO_DEPTH`.
- `fifo_full_next` out 1: count == `FIFO_DEPTH`-1.
- `fifo_empty` out 1: count == 0.
- `fifo_empty_next` out 1: count == 1.
- `fifo_count` out clog2(`FIFO_DEPTH`+1): occupancy.
- `overflow` out 1: one-cycle pulse, write attempted while full and not accepted.
- `underflow` out 1: one-cycle pulse, read attempted while empty.

## Operation
- Storage is a memory of `FIFO_DEPTH` x `CFG_FRAME_SIZE`. Write and read pointers are log2(`FIFO_DEPTH`) bits and wrap naturally from `FIFO_DEPTH`-1 to 0. Occupancy is tracked in a separate count register.
- Reset (`aresetn` low, async) sets pointers, count, `data_out`, `overflow` and `underflow` to 0. Outputs after reset: `fifo_empty`=1, `fifo_full`=0, `fifo_full_next`=0, `fifo_empty_next`=0, `fifo_count`=0. Memory contents are not reset.
- `clr_fifo`=1 has the highest priority. On that edge, pointers, count, `data_out`, `overflow` and `underflow` clear to 0. Any `fifo_write` or `fifo_read` in the same cycle is ignored, with no overflow or underflow pulse.
- Accepted read: `fifo_read`=1 and count≠0. `data_out` <= mem[rd_ptr], rd_ptr increments.
- Accepted write: `fifo_write`=1, and count≠`FIFO_DEPTH` or an accepted read occurs in the same cycle. mem[wr_ptr] <= `data_in`, wr_ptr increments.
- Count update: +1 for write only, -1 for read only, unchanged for both or neither.
- Simultaneous read and write when full: both accepted, count stays `FIFO_DEPTH`, no overflow.
- Simultaneous read and write when empty: the write is accepted and count becomes 1. The read is rejected and `underflow` pulses. `data_out` does not change.
- Rejected write when full without a read: memory and pointers are unchanged, and `overflow`=1 for one cycle.
- Rejected read: `data_out` holds its previous value, and `underflow`=1 for one cycle.
- `data_out` changes only on an accepted read or on a clear.
- With `FIFO_DEPTH`=2, `fifo_full_next` and `fifo_empty_next` are both asserted at count 1; this is legal.

## Timing
- Read latency is 1 cycle: data appears on `data_out` the cycle after the accepted `fifo_read` edge.
- Write-to-read latency: a word written on edge N is readable with `fifo_read` sampled at edge N+1 and appears on `data_out` after edge N+1.
- All flags and `fifo_count` are decoded from the registered count. They reflect the state after the most recent edge, with no combinational path from `fifo_write`/`fifo_read`.
- `overflow` and `underflow` are registered. They assert the cycle after the offending request and last exactly 1 cycle per offending cycle.
- The block is fully synchronous except for `aresetn`. Asserting it mid-operation immediately forces the reset values listed above.

## Test plan
- Reset, then idle: `fifo_empty`=1, `fifo_count`=0, `data_out`=0x00, `overflow`=`underflow`=0.
- Fill and drain (DEPTH=4, W=8): write 0x11, 0x22, 0x33, 0x44, then read 4 times.
  - `fifo_full_next`=1 after the 3rd write and `fifo_full`=1 after the 4th.
  - `data_out` shows 0x11, 0x22, 0x33, 0x44, each one cycle after its read.
  - `fifo_empty_next`=1 at count 1, and `fifo_empty`=1 at the end.
- Boundary errors: a 5th write while full gives an `overflow` pulse of 1 cycle, count stays 4, and the data order is unchanged. A read while empty gives an `underflow` pulse of 1 cycle, and `data_out` holds 0x44.
- Simultaneous events:
  - Read and write while full (writing 0x55) leaves count at 4 with no overflow; a subsequent drain yields 0x22, 0x33, 0x44, 0x55.
  - Read and write while empty (writing 0x66) gives count 1, an underflow pulse, and `data_out` unchanged.
- Wrap-around: 10 alternating write/read pairs with data 0x00..0x09 return `data_out` 0x00..0x09 in order across pointer wrap, and count never exceeds 1.
- Clear and async reset mid-operation:
  - With count 3, `clr_fifo` asserted together with `fifo_write` gives count 0, `fifo_empty`=1, no overflow, and the written data discarded.
  - Dropping `aresetn` asynchronously between edges immediately forces count 0 and `data_out` 0.
